piso_frame_serializer: RTL

- Upstream feeder for the serial shift-register stage: accepts a parallel word over a valid/ready handshake and emits it as a framed, LSB-first bitstream on `serial_out`.
- `serial_out` drives the downstream stage's `serial_in` directly.
- Frame format is start bit (0), DATA_W data bits, optional parity bit, stop bit (1). The line idles high.
- A configurable per-bit hold time lets a slower downstream consumer sample each bit.

---
 rtl/piso_frame_serializer.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/piso_frame_serializer.sv
`default_nettype none
// ============================================================================
// piso_frame_serializer : valid/ready parallel word in, framed LSB-first
//                         serial bitstream out (start, data, [parity], stop)
// Revision: 1.0
// ============================================================================
module piso_frame_serializer #(
  parameter int DATA_W     = 8,
  parameter int BIT_CYCLES = 1,
  parameter int PARITY_EN  = 1,
  parameter int PARITY_ODD = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] data_in,
  input  logic              data_valid,
  output logic              data_ready,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int c_cnt_w = (BIT_CYCLES > 1) ? $clog2(BIT_CYCLES) : 1;
  localparam int c_idx_w = (DATA_W > 1) ? $clog2(DATA_W) : 1;
  localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(BIT_CYCLES - 1);
  localparam logic [c_idx_w-1:0] c_idx_last = c_idx_w'(DATA_W - 1);
  localparam logic c_par_odd = (PARITY_ODD != 0);
  localparam logic c_par_en  = (PARITY_EN != 0);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } state_t;

  state_t              state_q,      state_d;
  logic [c_cnt_w-1:0]  bit_cnt_q,    bit_cnt_d;
  logic [c_idx_w-1:0]  idx_q,        idx_d;
  logic [DATA_W-1:0]   shreg_q,      shreg_d;
  logic                par_q,        par_d;
  logic                serial_out_q, serial_out_d;
  logic                frame_done_q, frame_done_d;

  logic w_hold_last;
  logic w_accept;

  assign w_hold_last = (bit_cnt_q == c_cnt_last);

  // Ready is forced low while reset is held; the last STOP hold cycle also
  // accepts so that back-to-back frames have no idle gap.
  assign data_ready = !rst && ((state_q == ST_IDLE) ||
                               ((state_q == ST_STOP) && w_hold_last));
  assign w_accept   = data_valid && data_ready;

  assign serial_out = serial_out_q;
  assign busy       = (state_q != ST_IDLE);
  assign frame_done = frame_done_q;

  always_comb begin
    state_d      = state_q;
    bit_cnt_d    = w_hold_last ? '0 : bit_cnt_q + c_cnt_w'(1);
    idx_d        = idx_q;
    shreg_d      = shreg_q;
    par_d        = par_q;
    frame_done_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        bit_cnt_d = '0;
        if (w_accept) begin
          state_d = ST_START;
          idx_d   = '0;
          shreg_d = data_in;
          par_d   = (^data_in) ^ c_par_odd;
        end
      end
      ST_START: begin
        if (w_hold_last) begin
          state_d = ST_DATA;
          idx_d   = '0;
        end
      end
      ST_DATA: begin
        if (w_hold_last) begin
          shreg_d = shreg_q >> 1;
          if (idx_q == c_idx_last) begin
            state_d = c_par_en ? ST_PARITY : ST_STOP;
          end else begin
            idx_d = idx_q + c_idx_w'(1);
          end
        end
      end
      ST_PARITY: begin
        if (w_hold_last) begin
          state_d = ST_STOP;
        end
      end
      ST_STOP: begin
        if (w_hold_last) begin
          frame_done_d = 1'b1;
          if (w_accept) begin
            state_d = ST_START;
            idx_d   = '0;
            shreg_d = data_in;
            par_d   = (^data_in) ^ c_par_odd;
          end else begin
            state_d = ST_IDLE;
          end
        end
      end
      default: begin
        state_d   = ST_IDLE;
        bit_cnt_d = '0;
      end
    endcase

    // Line level follows the state being entered, so the registered output
    // lines up with the registered state.
    unique case (state_d)
      ST_START:  serial_out_d = 1'b0;
      ST_DATA:   serial_out_d = shreg_d[0];
      ST_PARITY: serial_out_d = par_d;
      default:   serial_out_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      bit_cnt_q    <= '0;
      idx_q        <= '0;
      shreg_q      <= '0;
      par_q        <= 1'b0;
      serial_out_q <= 1'b1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      bit_cnt_q    <= bit_cnt_d;
      idx_q        <= idx_d;
      shreg_q      <= shreg_d;
      par_q        <= par_d;
      serial_out_q <= serial_out_d;
      frame_done_q <= frame_done_d;
    end
  end

endmodule
`default_nettype wire
